// File: rtl/frame_sequencer_if.sv
// Mode-select and pattern-ROM addressing bundle for the frame sequencer.
// Signal names are written from the sequencer's point of view: _i is driven
// into the sequencer, _o is driven by it.
interface frame_sequencer_if;
    logic [4:0] animation_i;
    logic [4:0] limit_i;
    logic       run_i;
    logic       step_i;
    logic [2:0] speed_i;
    logic [4:0] frame_o;
    logic [4:0] anim_o;
    logic       wrap_o;
    logic [1:0] state_o;

    // The sequencer itself consumes the mode inputs and drives the ROM address
    modport slave (
        input  animation_i, limit_i, run_i, step_i, speed_i,
        output frame_o, anim_o, wrap_o, state_o
    );

    // Whoever drives the mode inputs and watches the playback outputs
    modport master (
        output animation_i, limit_i, run_i, step_i, speed_i,
        input  frame_o, anim_o, wrap_o, state_o
    );
endinterface

// File: rtl/frame_sequencer.sv
// Animation playback timebase: prescaled tick, frame counter that wraps at
// the per-animation limit, and a run/pause/single-step controller.
// frame_o/anim_o address the pattern ROM; limit_i comes back from the
// animation lookup addressed by anim_o.
module frame_sequencer #(
    parameter int BASE_DIV = 4,
    parameter int CNT_W    = 24
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    frame_sequencer_if.slave     bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] BASE_DIV_W = CNT_W'(BASE_DIV);
    localparam logic [CNT_W-1:0] ONE_W      = CNT_W'(1);

    state_t           state_q, state_d;
    logic [4:0]       frame_q, frame_d;
    logic [4:0]       anim_q, anim_d;
    logic             wrap_q, wrap_d;
    logic [CNT_W-1:0] prescale_q, prescale_d;
    logic             step_q, step_d;

    logic [5:0]       effLimit;
    logic [CNT_W-1:0] periodM1;
    logic             tick;
    logic             stepRise;
    logic             frameOver;
    logic             atLast;
    logic             advance;

    // Limit decoding, prescaler terminal count and step edge detection.
    // The tick uses >= so that lowering speed_i below the current count
    // fires a tick straight away instead of running the counter past P-1.
    always_comb begin
        effLimit  = (bus.limit_i == 5'd0) ? 6'd32 : {1'b0, bus.limit_i};
        periodM1  = (CNT_W'(bus.speed_i) + ONE_W) * BASE_DIV_W - ONE_W;
        tick      = (prescale_q >= periodM1);
        stepRise  = bus.step_i & ~step_q;
        frameOver = ({1'b0, frame_q} >= effLimit);
        atLast    = ({1'b0, frame_q} == (effLimit - 6'd1));
    end

    // Next-state logic: animation change beats limit shrink beats the FSM.
    // With ena low every register simply holds, including the wrap pulse.
    always_comb begin
        state_d    = state_q;
        frame_d    = frame_q;
        anim_d     = anim_q;
        wrap_d     = wrap_q;
        prescale_d = prescale_q;
        step_d     = step_q;
        advance    = 1'b0;

        if (ena) begin
            step_d = bus.step_i;
            wrap_d = 1'b0;
            if (bus.animation_i != anim_q) begin
                anim_d     = bus.animation_i;
                frame_d    = 5'd0;
                prescale_d = '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (bus.run_i) begin
                            state_d    = RUN;
                            prescale_d = '0;
                        end else if (stepRise) begin
                            state_d = PAUSE;
                            advance = 1'b1;
                        end
                    end
                    RUN: begin
                        if (!bus.run_i) begin
                            state_d = PAUSE;
                        end else if (tick) begin
                            prescale_d = '0;
                            advance    = 1'b1;
                        end else begin
                            prescale_d = prescale_q + ONE_W;
                        end
                    end
                    PAUSE: begin
                        if (bus.run_i) begin
                            state_d = RUN;
                        end else if (stepRise) begin
                            advance = 1'b1;
                        end
                    end
                    default: begin
                        state_d = IDLE;
                    end
                endcase

                if (frameOver) begin
                    frame_d = 5'd0;
                end else if (advance) begin
                    if (atLast) begin
                        frame_d = 5'd0;
                        wrap_d  = 1'b1;
                    end else begin
                        frame_d = frame_q + 5'd1;
                    end
                end
            end
        end
    end

    // State register with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            frame_q    <= 5'd0;
            anim_q     <= 5'd0;
            wrap_q     <= 1'b0;
            prescale_q <= '0;
            step_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            frame_q    <= frame_d;
            anim_q     <= anim_d;
            wrap_q     <= wrap_d;
            prescale_q <= prescale_d;
            step_q     <= step_d;
        end
    end

    assign bus.frame_o = frame_q;
    assign bus.anim_o  = anim_q;
    assign bus.wrap_o  = wrap_q;
    assign bus.state_o = state_q;

endmodule

// File: tb/tb_frame_sequencer.sv
// Directed bench for frame_sequencer with BASE_DIV=4. Inputs change on the
// falling edge and outputs are sampled on the falling edge, half a cycle
// away from the active rising edge.
module tb_frame_sequencer;

    logic clk;
    logic rst_n;
    logic ena;
    int   checkCount;
    int   failCount;

    frame_sequencer_if bus ();

    frame_sequencer #(
        .BASE_DIV(4),
        .CNT_W(24)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .ena(ena),
        .bus(bus)
    );

    // 10 time-unit clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Drives all mode inputs at once
    task automatic applyStimulus(input logic [4:0] anim, input logic [4:0] limit,
                                 input logic run, input logic step,
                                 input logic [2:0] speed);
        bus.animation_i = anim;
        bus.limit_i     = limit;
        bus.run_i       = run;
        bus.step_i      = step;
        bus.speed_i     = speed;
    endtask

    // Main directed sequence; each phase builds on the state left by the last
    initial begin
        int  guard;
        int  prevFrame;
        int  wrapCount;
        int  earlyZero;
        checkCount = 0;
        failCount  = 0;
        ena        = 1'b1;
        rst_n      = 1'b1;
        applyStimulus(5'd2, 5'd6, 1'b0, 1'b0, 3'd0);

        // Reset values
        #1 rst_n = 1'b0;
        #2;
        checkOutput("resetFrame", 32'(bus.frame_o), 0);
        checkOutput("resetAnim",  32'(bus.anim_o),  0);
        checkOutput("resetWrap",  32'(bus.wrap_o),  0);
        checkOutput("resetState", 32'(bus.state_o), 0);

        // Release reset; the first edge latches animation 2 and stays IDLE
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("animLatch",  32'(bus.anim_o),  2);
        checkOutput("idleHold",   32'(bus.state_o), 0);

        // Playback at limit 6: four cycles per frame, wrap after frame 5
        bus.run_i = 1'b1;
        @(negedge clk);
        checkOutput("enterRun",   32'(bus.state_o), 1);
        checkOutput("runFrame0",  32'(bus.frame_o), 0);
        for (int k = 1; k <= 25; k++) begin
            @(negedge clk);
            checkOutput($sformatf("runFrame_k%0d", k), 32'(bus.frame_o), 32'((k / 4) % 6));
            checkOutput($sformatf("runWrap_k%0d", k),  32'(bus.wrap_o),  (k == 24) ? 1 : 0);
        end

        // Animation change at frame 3 restarts the frame and the prescaler
        guard = 0;
        while (bus.frame_o != 5'd3 && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("reachFrame3", 32'(bus.frame_o), 3);
        bus.animation_i = 5'd7;
        @(negedge clk);
        checkOutput("animChangeAnim",  32'(bus.anim_o),  7);
        checkOutput("animChangeFrame", 32'(bus.frame_o), 0);
        checkOutput("animChangeWrap",  32'(bus.wrap_o),  0);
        checkOutput("animChangeState", 32'(bus.state_o), 1);
        repeat (3) @(negedge clk);
        checkOutput("animChangeHold",  32'(bus.frame_o), 0);
        @(negedge clk);
        checkOutput("animChangeNext",  32'(bus.frame_o), 1);

        // Pause at frame 2, then single-step up to frame 9 under limit 10
        guard = 0;
        while (bus.frame_o != 5'd2 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("reachFrame2", 32'(bus.frame_o), 2);
        bus.run_i = 1'b0;
        @(negedge clk);
        checkOutput("pauseState", 32'(bus.state_o), 2);
        checkOutput("pauseFrame", 32'(bus.frame_o), 2);
        bus.limit_i = 5'd10;
        for (int i = 0; i < 7; i++) begin
            bus.step_i = 1'b1;
            @(negedge clk);
            checkOutput($sformatf("stepAdvance%0d", i), 32'(bus.frame_o), 32'(3 + i));
            repeat (4) @(negedge clk);
            checkOutput($sformatf("stepHeld%0d", i),    32'(bus.frame_o), 32'(3 + i));
            bus.step_i = 1'b0;
            repeat (5) @(negedge clk);
        end
        checkOutput("stepState", 32'(bus.state_o), 2);

        // Limit shrinks under the current frame: back to 0 without a wrap
        bus.limit_i = 5'd4;
        @(negedge clk);
        checkOutput("shrinkFrame", 32'(bus.frame_o), 0);
        checkOutput("shrinkWrap",  32'(bus.wrap_o),  0);
        checkOutput("shrinkState", 32'(bus.state_o), 2);

        // ena low: everything frozen despite run, steps and a new animation
        ena = 1'b0;
        bus.run_i = 1'b1;
        bus.animation_i = 5'd9;
        for (int c = 0; c < 20; c++) begin
            bus.step_i = c[1];
            @(negedge clk);
            checkOutput($sformatf("frozenFrame%0d", c), 32'(bus.frame_o), 0);
            checkOutput($sformatf("frozenAnim%0d", c),  32'(bus.anim_o),  7);
            checkOutput($sformatf("frozenState%0d", c), 32'(bus.state_o), 2);
        end
        bus.step_i = 1'b0;
        bus.animation_i = 5'd7;
        ena = 1'b1;

        // Resume from pause, then reset asynchronously between clock edges
        @(negedge clk);
        checkOutput("resumeState", 32'(bus.state_o), 1);
        guard = 0;
        while (bus.frame_o == 5'd0 && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("resumeAdvance", 32'(bus.frame_o), 1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("asyncRstFrame", 32'(bus.frame_o), 0);
        checkOutput("asyncRstAnim",  32'(bus.anim_o),  0);
        checkOutput("asyncRstState", 32'(bus.state_o), 0);
        checkOutput("asyncRstWrap",  32'(bus.wrap_o),  0);
        bus.run_i = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("postRstIdle",  32'(bus.state_o), 0);
        checkOutput("postRstFrame", 32'(bus.frame_o), 0);
        checkOutput("postRstAnim",  32'(bus.anim_o),  7);

        // Speed 1 gives an 8-cycle period; dropping to speed 0 at count 6 ticks at once
        bus.speed_i = 3'd1;
        bus.run_i   = 1'b1;
        @(negedge clk);
        checkOutput("restartRun", 32'(bus.state_o), 1);
        repeat (6) @(negedge clk);
        checkOutput("slowNoTick", 32'(bus.frame_o), 0);
        bus.speed_i = 3'd0;
        @(negedge clk);
        checkOutput("speedDropTick", 32'(bus.frame_o), 1);

        // limit 0 means 32 frames: exactly one wrap, from 31, and no other return to 0
        bus.limit_i = 5'd0;
        prevFrame = 1;
        wrapCount = 0;
        earlyZero = 0;
        guard     = 0;
        while (wrapCount == 0 && guard < 200) begin
            @(negedge clk);
            guard++;
            if (bus.wrap_o) begin
                wrapCount++;
                checkOutput("limit0WrapFrom", 32'(prevFrame), 31);
                checkOutput("limit0WrapTo",   32'(bus.frame_o), 0);
            end else if (bus.frame_o == 5'd0 && prevFrame != 0) begin
                earlyZero++;
            end
            prevFrame = int'(bus.frame_o);
        end
        checkOutput("limit0WrapSeen",    32'(wrapCount), 1);
        checkOutput("limit0NoEarlyZero", 32'(earlyZero), 0);
        @(negedge clk);
        checkOutput("limit0WrapPulse", 32'(bus.wrap_o), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
